// File: rtl/barret_reduce_pipe.sv
// Streaming three-stage Barrett reducer: dout_r = din_a mod Q for any din_a < 2^(2*QW).
// Define BARRET_RANGE_CHECK_EN to flag inputs din_a >= Q*Q on dout_err; otherwise dout_err is 0.
module barret_reduce_pipe #(
    parameter int unsigned Q  = 2239,
    parameter int unsigned QW = 12,
    parameter int unsigned TW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [2*QW-1:0] din_a,
    input  logic [TW-1:0]   din_tag,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [QW-1:0]   dout_r,
    output logic [TW-1:0]   dout_tag,
    output logic            dout_err
);

    localparam logic [2*QW:0] POW2 = (2*QW+1)'(1'b1) << (2*QW);
    localparam logic [2*QW:0] MU   = POW2 / (2*QW+1)'(Q);
    localparam logic [QW+1:0] Q1   = (QW+2)'(Q);
    localparam logic [QW+1:0] Q2   = Q1 << 1;
`ifdef BARRET_RANGE_CHECK_EN
    localparam logic [2*QW-1:0] QQ = (2*QW)'(Q) * (2*QW)'(Q);
`endif

    logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [QW+1:0]   a1_q, a1_d, t1_q, t1_d, r2_q, r2_d;
    logic [TW-1:0]   tag1_q, tag1_d, tag2_q, tag2_d, dout_tag_q, dout_tag_d;
    logic            err1_q, err1_d, err2_q, err2_d, dout_err_q, dout_err_d;
    logic [QW-1:0]   dout_r_q, dout_r_d;
    logic            adv_s, err_s;
    logic [3*QW:0]   qh_s;
    logic [QW+1:0]   tq_s, rr_s;

    // Datapath arithmetic; the remainder only needs QW+2 bits since it is below 3Q.
    always_comb begin
        adv_s = ~v3_q | dout_ready;
        qh_s  = (3*QW+1)'(din_a[2*QW-1:QW]) * (3*QW+1)'(MU);
        tq_s  = t1_q * Q1;
`ifdef BARRET_RANGE_CHECK_EN
        err_s = (din_a >= QQ);
`else
        err_s = 1'b0;
`endif
        if (r2_q >= Q2) begin
            rr_s = r2_q - Q2;
        end else if (r2_q >= Q1) begin
            rr_s = r2_q - Q1;
        end else begin
            rr_s = r2_q;
        end
    end

    // Next-state: the whole pipe advances together or holds together.
    always_comb begin
        if (adv_s) begin
            v1_d       = din_valid;
            a1_d       = din_a[QW+1:0];
            t1_d       = (QW+2)'(qh_s >> QW);
            tag1_d     = din_tag;
            err1_d     = err_s;
            v2_d       = v1_q;
            r2_d       = a1_q - tq_s;
            tag2_d     = tag1_q;
            err2_d     = err1_q;
            v3_d       = v2_q;
            dout_r_d   = QW'(rr_s);
            dout_tag_d = tag2_q;
            dout_err_d = err2_q;
        end else begin
            v1_d       = v1_q;
            a1_d       = a1_q;
            t1_d       = t1_q;
            tag1_d     = tag1_q;
            err1_d     = err1_q;
            v2_d       = v2_q;
            r2_d       = r2_q;
            tag2_d     = tag2_q;
            err2_d     = err2_q;
            v3_d       = v3_q;
            dout_r_d   = dout_r_q;
            dout_tag_d = dout_tag_q;
            dout_err_d = dout_err_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            a1_q       <= '0;
            t1_q       <= '0;
            tag1_q     <= '0;
            err1_q     <= 1'b0;
            v2_q       <= 1'b0;
            r2_q       <= '0;
            tag2_q     <= '0;
            err2_q     <= 1'b0;
            v3_q       <= 1'b0;
            dout_r_q   <= '0;
            dout_tag_q <= '0;
            dout_err_q <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            a1_q       <= a1_d;
            t1_q       <= t1_d;
            tag1_q     <= tag1_d;
            err1_q     <= err1_d;
            v2_q       <= v2_d;
            r2_q       <= r2_d;
            tag2_q     <= tag2_d;
            err2_q     <= err2_d;
            v3_q       <= v3_d;
            dout_r_q   <= dout_r_d;
            dout_tag_q <= dout_tag_d;
            dout_err_q <= dout_err_d;
        end
    end

    assign din_ready  = adv_s;
    assign dout_valid = v3_q;
    assign dout_r     = dout_r_q;
    assign dout_tag   = dout_tag_q;
    assign dout_err   = dout_err_q;

endmodule

// File: tb/tb_barret_reduce_pipe.sv
// Directed and constrained-random checks of barret_reduce_pipe at Q=2239/QW=12 and Q=8380417/QW=23.
module tb_barret_reduce_pipe;

    localparam int unsigned Q   = 2239;
    localparam int unsigned QW  = 12;
    localparam int unsigned TW  = 4;
    localparam int unsigned QB  = 8380417;
    localparam int unsigned QWB = 23;
`ifdef BARRET_RANGE_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            din_valid, din_ready, dout_valid, dout_ready, dout_err;
    logic [2*QW-1:0] din_a;
    logic [TW-1:0]   din_tag, dout_tag;
    logic [QW-1:0]   dout_r;

    logic             b_din_valid, b_din_ready, b_dout_valid, b_dout_err;
    logic             b_dout_ready;
    logic [2*QWB-1:0] b_din_a;
    logic [TW-1:0]    b_din_tag, b_dout_tag;
    logic [QWB-1:0]   b_dout_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    barret_reduce_pipe #(.Q(Q), .QW(QW), .TW(TW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .din_valid(din_valid), .din_ready(din_ready), .din_a(din_a), .din_tag(din_tag),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_r(dout_r),
        .dout_tag(dout_tag), .dout_err(dout_err)
    );

    barret_reduce_pipe #(.Q(QB), .QW(QWB), .TW(TW)) u_dut_wide (
        .clk(clk), .rst_n(rst_n),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .din_a(b_din_a), .din_tag(b_din_tag),
        .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout_r(b_dout_r),
        .dout_tag(b_dout_tag), .dout_err(b_dout_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; din_valid = 1'b0; din_a = '0; din_tag = '0; dout_ready = 1'b1;
        b_din_valid = 1'b0; b_din_a = '0; b_din_tag = '0; b_dout_ready = 1'b1;
        #3;
        checks++;
        if (dout_valid !== 1'b0 || dout_r !== 12'd0 || dout_tag !== 4'd0 || dout_err !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got v=%b r=%0d tag=%0d err=%b rdy=%b, want v=0 r=0 tag=0 err=0 rdy=1",
                     dout_valid, dout_r, dout_tag, dout_err, din_ready);
        end
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [23:0] va [4];
        logic [11:0] er [4];
        va = '{24'd0, 24'd2239, 24'd4477, 24'd5008644};
        er = '{12'd0, 12'd0, 12'd2238, 12'd1};
        dout_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                din_valid = 1'b1; din_a = va[c]; din_tag = 4'(c + 1);
            end else begin
                din_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (dout_valid !== 1'((c >= 3) && (c <= 6))) begin
                errors++;
                $display("FAIL b2b_valid cyc %0d: got %b, want %b", c, dout_valid, (c >= 3) && (c <= 6));
            end
            if ((c >= 3) && (c <= 6)) begin
                checks++;
                if (dout_r !== er[c-3] || dout_tag !== 4'(c - 2)) begin
                    errors++;
                    $display("FAIL b2b_data cyc %0d: got r=%0d tag=%0d, want r=%0d tag=%0d",
                             c, dout_r, dout_tag, er[c-3], c - 2);
                end
            end
            tick;
        end
    endtask

    task automatic test_random_stream;
        logic [11:0] exp_r [$];
        logic [3:0]  exp_t [$];
        logic        acc, stall_prev;
        logic [11:0] prev_r, want_r;
        logic [3:0]  prev_t, want_t;
        acc = 1'b0; stall_prev = 1'b0; prev_r = '0; prev_t = '0;
        din_valid = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!din_valid || acc) begin
                din_valid = (cyc < 500) && ($urandom_range(0, 3) != 0);
                din_a     = 24'($urandom_range(0, 32'h00FF_FFFF));
                din_tag   = 4'($urandom_range(0, 15));
            end
            dout_ready = (cyc >= 500) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stall_prev) begin
                checks++;
                if (dout_valid !== 1'b1 || dout_r !== prev_r || dout_tag !== prev_t) begin
                    errors++;
                    $display("FAIL stream_hold cyc %0d: got v=%b r=%0d tag=%0d, want v=1 r=%0d tag=%0d",
                             cyc, dout_valid, dout_r, dout_tag, prev_r, prev_t);
                end
            end
            if (dout_valid && dout_ready) begin
                checks++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra cyc %0d: got r=%0d with no sample outstanding, want none", cyc, dout_r);
                end else begin
                    want_r = exp_r.pop_front();
                    want_t = exp_t.pop_front();
                    if (dout_r !== want_r || dout_tag !== want_t) begin
                        errors++;
                        $display("FAIL stream_data cyc %0d: got r=%0d tag=%0d, want r=%0d tag=%0d",
                                 cyc, dout_r, dout_tag, want_r, want_t);
                    end
                end
            end
            acc = din_valid && din_ready;
            if (acc) begin
                exp_r.push_back(12'(din_a % Q));
                exp_t.push_back(din_tag);
            end
            stall_prev = dout_valid && !dout_ready;
            prev_r = dout_r;
            prev_t = dout_tag;
            tick;
        end
        din_valid = 1'b0;
        checks++;
        if (exp_r.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: got %0d samples outstanding, want 0", exp_r.size());
        end
    endtask

    task automatic test_stall;
        logic [23:0] sa [4];
        logic [11:0] er [4];
        int idx, acc_cnt;
        sa = '{24'd100000, 24'd16777215, 24'd4478, 24'd12345};
        er = '{12'd1484, 12'd388, 12'd0, 12'd1150};
        idx = 0; acc_cnt = 0;
        dout_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            din_valid = 1'b1; din_a = sa[idx]; din_tag = 4'(idx + 5);
            @(negedge clk);
            if (din_ready) begin
                acc_cnt++;
                idx++;
            end
            if (c == 5) begin
                checks++;
                if (din_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: got %b, want 0", din_ready);
                end
            end
            tick;
        end
        checks++;
        if (acc_cnt != 3) begin
            errors++;
            $display("FAIL stall_accepted: got %0d, want 3", acc_cnt);
        end
        dout_ready = 1'b1;
        din_a = sa[3]; din_tag = 4'd8;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (dout_valid !== 1'(c < 4)) begin
                errors++;
                $display("FAIL stall_drain_valid cyc %0d: got %b, want %b", c, dout_valid, c < 4);
            end else if (c < 4) begin
                checks++;
                if (dout_r !== er[c] || dout_tag !== 4'(c + 5)) begin
                    errors++;
                    $display("FAIL stall_drain_data cyc %0d: got r=%0d tag=%0d, want r=%0d tag=%0d",
                             c, dout_r, dout_tag, er[c], c + 5);
                end
            end
            tick;
            din_valid = 1'b0;
        end
    endtask

    task automatic test_range_check;
        logic [23:0] va [3];
        logic [11:0] er [3];
        logic        ee [3];
        va = '{24'd5013121, 24'd5013120, 24'd16777215};
        er = '{12'd0, 12'd2238, 12'd388};
        ee = '{ERR_ON, 1'b0, ERR_ON};
        dout_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                din_valid = 1'b1; din_a = va[c]; din_tag = 4'(c + 1);
            end else begin
                din_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (dout_valid !== 1'b1 || dout_r !== er[c-3] || dout_err !== ee[c-3]) begin
                    errors++;
                    $display("FAIL range cyc %0d: got v=%b r=%0d err=%b, want v=1 r=%0d err=%b",
                             c, dout_valid, dout_r, dout_err, er[c-3], ee[c-3]);
                end
            end
            tick;
        end
    endtask

    task automatic test_async_reset;
        dout_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            din_valid = 1'b1; din_a = 24'(1000 * (c + 1)); din_tag = 4'(c + 1);
            tick;
        end
        din_valid = 1'b0;
        #2;
        checks++;
        if (dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got v=%b, want 1", dout_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || dout_r !== 12'd0 || dout_tag !== 4'd0) begin
            errors++;
            $display("FAIL areset_now: got v=%b r=%0d tag=%0d, want v=0 r=0 tag=0", dout_valid, dout_r, dout_tag);
        end
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 4) begin
                din_valid = 1'b1; din_a = 24'd5000; din_tag = 4'd9;
            end else begin
                din_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (dout_valid !== 1'(c == 7)) begin
                errors++;
                $display("FAIL areset_after cyc %0d: got v=%b, want %b", c, dout_valid, c == 7);
            end else if (c == 7 && (dout_r !== 12'd522 || dout_tag !== 4'd9)) begin
                errors++;
                $display("FAIL areset_resume: got r=%0d tag=%0d, want r=522 tag=9", dout_r, dout_tag);
            end
            tick;
        end
    endtask

    task automatic test_wide;
        logic [45:0] bv [5];
        logic [22:0] want_r;
        logic        want_e;
        logic [45:0] qq;
        qq = 46'(QB) * 46'(QB);
        bv = '{46'd0, 46'd8380417, qq - 46'd1, {46{1'b1}}, 46'h123_4567_89AB};
        for (int c = 0; c < 8; c++) begin
            if (c < 5) begin
                b_din_valid = 1'b1; b_din_a = bv[c]; b_din_tag = 4'(c + 1);
            end else begin
                b_din_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (b_dout_valid !== 1'(c >= 3)) begin
                errors++;
                $display("FAIL wide_valid cyc %0d: got %b, want %b", c, b_dout_valid, c >= 3);
            end else if (c >= 3) begin
                want_r = 23'(bv[c-3] % 46'(QB));
                want_e = ERR_ON && (bv[c-3] >= qq);
                if (b_dout_r !== want_r || b_dout_tag !== 4'(c - 2) || b_dout_err !== want_e) begin
                    errors++;
                    $display("FAIL wide_data cyc %0d: got r=%0d tag=%0d err=%b, want r=%0d tag=%0d err=%b",
                             c, b_dout_r, b_dout_tag, b_dout_err, want_r, c - 2, want_e);
                end
            end
            tick;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random_stream();
        test_stall();
        test_range_check();
        test_async_reset();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end within the time limit");
        $fatal(1);
    end

endmodule
